// File: rtl/lap_buffer.sv
// Lap buffer: four-entry circular store of captured stopwatch times with a live/recall view.
// Optional macro LAP_OVERWRITE_EN: a lap taken while full replaces the oldest entry instead of being dropped.
module lap_buffer (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_lap,
    input  logic       i_recall,
    input  logic       i_clear,
    input  logic [6:0] msec,
    input  logic [5:0] sec,
    input  logic [5:0] min,
    input  logic [4:0] hour,
    output logic [6:0] o_msec,
    output logic [5:0] o_sec,
    output logic [5:0] o_min,
    output logic [4:0] o_hour,
    output logic       o_view_lap,
    output logic [1:0] o_lap_idx,
    output logic [2:0] o_lap_cnt,
    output logic       o_full
);

    typedef enum logic {LIVE, RECALL} state_t;

    state_t      state, state_next;
    logic [1:0]  head, head_next;
    logic [1:0]  idx, idx_next;
    logic [2:0]  count, count_next;
    logic        wr_en;
    logic [1:0]  wr_addr;
    logic [1:0]  rd_addr;
    logic        full;
    logic [23:0] live_time;
    logic [23:0] shown;
    logic [23:0] mem [4];

    assign full      = (count == 3'd4);
    assign live_time = {hour, min, sec, msec};
    assign rd_addr   = head + idx;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= LIVE;
            head  <= 2'd0;
            idx   <= 2'd0;
            count <= 3'd0;
        end else begin
            state <= state_next;
            head  <= head_next;
            idx   <= idx_next;
            count <= count_next;
        end
    end

    // Pulse priority is clear, then lap, then recall; a lower pulse in the same cycle is dropped.
    always_comb begin
        state_next = state;
        head_next  = head;
        idx_next   = idx;
        count_next = count;
        wr_en      = 1'b0;
        wr_addr    = head + count[1:0];
        if (i_clear) begin
            state_next = LIVE;
            head_next  = 2'd0;
            idx_next   = 2'd0;
            count_next = 3'd0;
        end else if (i_lap) begin
            if (!full) begin
                wr_en      = 1'b1;
                count_next = count + 3'd1;
            end
`ifdef LAP_OVERWRITE_EN
            else begin
                wr_en     = 1'b1;
                wr_addr   = head;
                head_next = head + 2'd1;
            end
`endif
        end else if (i_recall) begin
            if (state == LIVE) begin
                if (count != 3'd0) begin
                    state_next = RECALL;
                    idx_next   = 2'd0;
                end
            end else if ({1'b0, idx} < (count - 3'd1)) begin
                idx_next = idx + 2'd1;
            end else begin
                state_next = LIVE;
                idx_next   = 2'd0;
            end
        end
    end

    // Lap storage is not reset; only the head/count bookkeeping decides what is valid.
    always_ff @(posedge clk) begin
        if (!reset && wr_en) begin
            mem[wr_addr] <= live_time;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shown <= 24'd0;
        end else if (state == RECALL) begin
            shown <= mem[rd_addr];
        end else begin
            shown <= live_time;
        end
    end

    assign {o_hour, o_min, o_sec, o_msec} = shown;
    assign o_view_lap = (state == RECALL);
    assign o_lap_idx  = idx;
    assign o_lap_cnt  = count;
    assign o_full     = full;

endmodule

// File: tb/tb_lap_buffer.sv
// Directed self-checking bench for lap_buffer; expectations follow LAP_OVERWRITE_EN when it is defined.
module tb_lap_buffer;

    logic       clk = 1'b0;
    logic       reset;
    logic       i_lap, i_recall, i_clear;
    logic [6:0] msec;
    logic [5:0] sec, min;
    logic [4:0] hour;
    logic [6:0] o_msec;
    logic [5:0] o_sec, o_min;
    logic [4:0] o_hour;
    logic       o_view_lap;
    logic [1:0] o_lap_idx;
    logic [2:0] o_lap_cnt;
    logic       o_full;
    logic [23:0] shownTime;

    int vecCount = 0;
    int errCount = 0;

    always #5 clk = ~clk;

    lap_buffer dut (
        .clk        (clk),
        .reset      (reset),
        .i_lap      (i_lap),
        .i_recall   (i_recall),
        .i_clear    (i_clear),
        .msec       (msec),
        .sec        (sec),
        .min        (min),
        .hour       (hour),
        .o_msec     (o_msec),
        .o_sec      (o_sec),
        .o_min      (o_min),
        .o_hour     (o_hour),
        .o_view_lap (o_view_lap),
        .o_lap_idx  (o_lap_idx),
        .o_lap_cnt  (o_lap_cnt),
        .o_full     (o_full)
    );

    assign shownTime = {o_hour, o_min, o_sec, o_msec};

    task automatic checkOutput(input string tag, input logic [23:0] observed, input logic [23:0] expected);
        vecCount++;
        if (observed !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle pulse, sampled on the next edge; returns 1 time unit after it.
    task automatic applyStimulus(input logic lap, input logic recall, input logic clear);
        i_lap    = lap;
        i_recall = recall;
        i_clear  = clear;
        tick();
        i_lap    = 1'b0;
        i_recall = 1'b0;
        i_clear  = 1'b0;
    endtask

    task automatic setTime(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s, input logic [6:0] ms);
        hour = h;
        min  = m;
        sec  = s;
        msec = ms;
    endtask

    function automatic logic [23:0] tv(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s, input logic [6:0] ms);
        return {h, m, s, ms};
    endfunction

    task automatic recallCheck(input logic [6:0] ms, input logic [1:0] idx);
        applyStimulus(1'b0, 1'b1, 1'b0);
        tick();
        checkOutput("recall_view", {23'd0, o_view_lap}, 24'd1);
        checkOutput("recall_idx", {22'd0, o_lap_idx}, {22'd0, idx});
        checkOutput("recall_time", shownTime, tv(5'd0, 6'd0, 6'd0, ms));
    endtask

    initial begin
        int base;
        reset    = 1'b1;
        i_lap    = 1'b0;
        i_recall = 1'b0;
        i_clear  = 1'b0;
        setTime(5'd0, 6'd1, 6'd2, 7'd34);
        tick();
        tick();
        checkOutput("reset_time", shownTime, 24'd0);
        checkOutput("reset_view", {23'd0, o_view_lap}, 24'd0);
        checkOutput("reset_idx", {22'd0, o_lap_idx}, 24'd0);
        checkOutput("reset_cnt", {21'd0, o_lap_cnt}, 24'd0);
        checkOutput("reset_full", {23'd0, o_full}, 24'd0);

        reset = 1'b0;
        tick();
        checkOutput("live_time", shownTime, tv(5'd0, 6'd1, 6'd2, 7'd34));
        checkOutput("live_view", {23'd0, o_view_lap}, 24'd0);
        setTime(5'd0, 6'd1, 6'd2, 7'd35);
        checkOutput("live_latency_old", shownTime, tv(5'd0, 6'd1, 6'd2, 7'd34));
        tick();
        checkOutput("live_latency_new", shownTime, tv(5'd0, 6'd1, 6'd2, 7'd35));

        for (int i = 1; i <= 3; i++) begin
            setTime(5'd0, 6'd0, 6'd0, 7'(i * 10));
            applyStimulus(1'b1, 1'b0, 1'b0);
        end
        checkOutput("three_laps_cnt", {21'd0, o_lap_cnt}, 24'd3);
        setTime(5'd0, 6'd0, 6'd0, 7'd99);
        recallCheck(7'd10, 2'd0);
        recallCheck(7'd20, 2'd1);
        recallCheck(7'd30, 2'd2);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("recall_exit_view", {23'd0, o_view_lap}, 24'd0);
        checkOutput("recall_exit_idx", {22'd0, o_lap_idx}, 24'd0);
        checkOutput("recall_exit_cnt", {21'd0, o_lap_cnt}, 24'd3);
        tick();
        checkOutput("recall_exit_live", shownTime, tv(5'd0, 6'd0, 6'd0, 7'd99));

        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("clear_cnt", {21'd0, o_lap_cnt}, 24'd0);

        for (int i = 1; i <= 5; i++) begin
            setTime(5'd0, 6'd0, 6'd0, 7'(i));
            applyStimulus(1'b1, 1'b0, 1'b0);
        end
        checkOutput("full_cnt", {21'd0, o_lap_cnt}, 24'd4);
        checkOutput("full_flag", {23'd0, o_full}, 24'd1);
        setTime(5'd0, 6'd0, 6'd0, 7'd99);
`ifdef LAP_OVERWRITE_EN
        base = 2;
`else
        base = 1;
`endif
        for (int i = 0; i < 4; i++) begin
            recallCheck(7'(base + i), 2'(i));
        end
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("full_exit_view", {23'd0, o_view_lap}, 24'd0);

        applyStimulus(1'b1, 1'b0, 1'b1);
        checkOutput("clear_lap_cnt", {21'd0, o_lap_cnt}, 24'd0);
        checkOutput("clear_lap_full", {23'd0, o_full}, 24'd0);
        checkOutput("clear_lap_view", {23'd0, o_view_lap}, 24'd0);

        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("empty_recall_view", {23'd0, o_view_lap}, 24'd0);
        checkOutput("empty_recall_idx", {22'd0, o_lap_idx}, 24'd0);

        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("lap_recall_cnt", {21'd0, o_lap_cnt}, 24'd1);
        checkOutput("lap_recall_view", {23'd0, o_view_lap}, 24'd0);

        applyStimulus(1'b0, 1'b0, 1'b1);
        setTime(5'd0, 6'd0, 6'd0, 7'd7);
        applyStimulus(1'b1, 1'b0, 1'b0);
        setTime(5'd0, 6'd0, 6'd0, 7'd8);
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        tick();
        checkOutput("mid_recall_view", {23'd0, o_view_lap}, 24'd1);
        checkOutput("mid_recall_time", shownTime, tv(5'd0, 6'd0, 6'd0, 7'd7));
        setTime(5'd1, 6'd2, 6'd3, 7'd4);
        reset = 1'b1;
        i_recall = 1'b1;
        tick();
        i_recall = 1'b0;
        checkOutput("mid_reset_time", shownTime, 24'd0);
        checkOutput("mid_reset_view", {23'd0, o_view_lap}, 24'd0);
        checkOutput("mid_reset_idx", {22'd0, o_lap_idx}, 24'd0);
        checkOutput("mid_reset_cnt", {21'd0, o_lap_cnt}, 24'd0);
        checkOutput("mid_reset_full", {23'd0, o_full}, 24'd0);
        reset = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
        $finish;
    end

endmodule
